// File: rtl/serial_shift_unit.sv
// Bit-serial lsl/lsr/asr unit: one bit of shift per clock, with valid/ready handshakes on
// the request and result sides and a synchronous kill for pipeline flushes.
module serial_shift_unit #(
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               shift_type,
    input  logic [WIDTH-1:0]         operand,
    input  logic [$clog2(WIDTH)-1:0] amount,
    input  logic                     kill,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         result,
    output logic                     illegal
);
    localparam int AW = $clog2(WIDTH);

    localparam logic [1:0] TYPE_LSL = 2'b00;
    localparam logic [1:0] TYPE_LSR = 2'b01;
    localparam logic [1:0] TYPE_ILL = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [1:0]       type_reg;
    logic [AW-1:0]    count_reg;
    logic [WIDTH-1:0] result_reg;
    logic             illegal_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;

    logic [WIDTH-1:0] step_next;
    logic             req_illegal;

    assign req_illegal = (shift_type == TYPE_ILL);

    // One-bit step of the held value according to the latched shift type.
    always_comb begin
        step_next = result_reg;
        case (type_reg)
            TYPE_LSL: step_next = {result_reg[WIDTH-2:0], 1'b0};
            TYPE_LSR: step_next = {1'b0, result_reg[WIDTH-1:1]};
            default:  step_next = {result_reg[WIDTH-1], result_reg[WIDTH-1:1]};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            type_reg      <= TYPE_LSL;
            count_reg     <= '0;
            result_reg    <= '0;
            illegal_reg   <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else if (kill) begin
            // Flush wins over everything; in IDLE this simply blocks acceptance.
            state_reg     <= IDLE;
            illegal_reg   <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        type_reg     <= shift_type;
                        count_reg    <= amount;
                        illegal_reg  <= req_illegal;
                        in_ready_reg <= 1'b0;
                        if (req_illegal) begin
                            result_reg    <= '0;
                            state_reg     <= DONE;
                            out_valid_reg <= 1'b1;
                        end else if (amount == '0) begin
                            result_reg    <= operand;
                            state_reg     <= DONE;
                            out_valid_reg <= 1'b1;
                        end else begin
                            result_reg <= operand;
                            state_reg  <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    result_reg <= step_next;
                    count_reg  <= count_reg - 1'b1;
                    if (count_reg == AW'(1)) begin
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign illegal   = illegal_reg;

endmodule

// File: tb/tb_serial_shift_unit.sv
// Directed bench for serial_shift_unit: hand-computed shift results, latencies,
// backpressure, asynchronous reset mid-shift and kill behaviour.
module tb_serial_shift_unit;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  shift_type;
    logic [31:0] operand;
    logic [4:0]  amount;
    logic        kill;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        illegal;

    int errors = 0;
    int checks = 0;
    int lat;

    serial_shift_unit #(.WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .shift_type(shift_type),
        .operand(operand),
        .amount(amount),
        .kill(kill),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request and return the number of edges, accept edge included,
    // until out_valid is seen (sampled 1 time unit after each edge).
    task automatic do_req(input logic [1:0] t, input logic [31:0] op, input logic [4:0] amt,
                          output int latency);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        shift_type = t;
        operand    = op;
        amount     = amt;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        latency  = 1;
        while (!out_valid && latency < 100) begin
            @(posedge clk);
            #1;
            latency++;
        end
        $display("req type=%b op=0x%08h amt=%0d -> result=0x%08h illegal=%0b latency=%0d",
                 t, op, amt, result, illegal, latency);
    endtask

    // Let the pending result hand off (out_ready assumed high) and confirm return to IDLE.
    task automatic finish_handoff(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_ov_drop"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_rdy_rise"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; shift_type = 2'b00; operand = '0; amount = '0;
        kill = 1'b0; out_ready = 1'b1;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // 1: lsl 1 by 31
        do_req(2'b00, 32'h0000_0001, 5'd31, lat);
        check("t1_lat", lat, 32'd32);
        check("t1_result", result, 32'h8000_0000);
        check("t1_illegal", {31'd0, illegal}, 32'd0);
        finish_handoff("t1");

        // 2: asr / lsr of 0x80000000 by 4
        do_req(2'b11, 32'h8000_0000, 5'd4, lat);
        check("t2_asr_lat", lat, 32'd5);
        check("t2_asr_result", result, 32'hF800_0000);
        finish_handoff("t2a");
        do_req(2'b01, 32'h8000_0000, 5'd4, lat);
        check("t2_lsr_lat", lat, 32'd5);
        check("t2_lsr_result", result, 32'h0800_0000);
        finish_handoff("t2l");

        // boundary: full-width shifts
        do_req(2'b11, 32'h8000_1234, 5'd31, lat);
        check("asr31_result", result, 32'hFFFF_FFFF);
        finish_handoff("asr31");
        do_req(2'b01, 32'hC000_0000, 5'd31, lat);
        check("lsr31_result", result, 32'h0000_0001);
        finish_handoff("lsr31");

        // 3: amount 0 and illegal type
        do_req(2'b01, 32'hDEAD_BEEF, 5'd0, lat);
        check("t3_zero_lat", lat, 32'd1);
        check("t3_zero_result", result, 32'hDEAD_BEEF);
        check("t3_zero_illegal", {31'd0, illegal}, 32'd0);
        finish_handoff("t3z");
        do_req(2'b10, 32'h1234_5678, 5'd3, lat);
        check("t3_ill_lat", lat, 32'd1);
        check("t3_ill_result", result, 32'd0);
        check("t3_ill_flag", {31'd0, illegal}, 32'd1);
        finish_handoff("t3i");

        // 4: backpressure with ignored in_valid pulses
        out_ready = 1'b0;
        do_req(2'b00, 32'h0000_000F, 5'd4, lat);
        check("t4_lat", lat, 32'd5);
        check("t4_result", result, 32'h0000_00F0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid   = i[0];
            shift_type = 2'b10;
            operand    = 32'hAAAA_5555;
            amount     = 5'd1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("t4_hold_ov", {31'd0, out_valid}, 32'd1);
        check("t4_hold_result", result, 32'h0000_00F0);
        check("t4_hold_illegal", {31'd0, illegal}, 32'd0);
        check("t4_hold_rdy", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        finish_handoff("t4");

        // 5: asynchronous reset in the middle of SHIFT
        do_req(2'b00, 32'h0000_0001, 5'd20, lat);
        // do_req waited for out_valid; request again and interrupt instead
        finish_handoff("t5pre");
        @(negedge clk);
        shift_type = 2'b00; operand = 32'h0000_0003; amount = 5'd20; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); @(posedge clk); @(posedge clk);
        #1;
        check("t5_busy_rdy", {31'd0, in_ready}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_ov", {31'd0, out_valid}, 32'd0);
        check("t5_rst_result", result, 32'd0);
        check("t5_rst_rdy", {31'd0, in_ready}, 32'd1);
        $display("async reset mid-shift: in_ready=%0b out_valid=%0b result=0x%08h",
                 in_ready, out_valid, result);
        @(negedge clk);
        rst = 1'b0;

        // 6: kill on the third shift step of an 8-step shift
        @(negedge clk);
        shift_type = 2'b01; operand = 32'hFFFF_0000; amount = 5'd8; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("t6_kill_rdy", {31'd0, in_ready}, 32'd1);
        check("t6_kill_ov", {31'd0, out_valid}, 32'd0);
        check("t6_kill_illegal", {31'd0, illegal}, 32'd0);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid) lat++;
        end
        check("t6_no_result", lat, 32'd0);
        $display("kill mid-shift: in_ready=%0b out_valid cycles after kill=%0d", in_ready, lat);
        do_req(2'b11, 32'h8000_0010, 5'd3, lat);
        check("t6_next_lat", lat, 32'd4);
        check("t6_next_result", result, 32'hF000_0002);
        finish_handoff("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
